// File: rtl/frame_dump_trigger_pkg.sv
// Shared constants for the frame dump trigger: state encoding and default counter width.
package frame_dump_trigger_pkg;
  localparam int unsigned CW_DEFAULT = 32;

  localparam logic [1:0] WAITDL = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] ARMED  = 2'd2;
  localparam logic [1:0] DUMP   = 2'd3;
endpackage

// File: rtl/frame_dump_trigger_sync_edge.sv
// Two-flop synchronizer plus a delay flop; emits synchronized level and its rise/fall strobes.
module frame_dump_trigger_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      dly_q <= RST_VAL;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      dly_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = ~dly_q & s2_q;
  assign fall_o = dly_q & ~s2_q;
endmodule

// File: rtl/frame_dump_trigger.sv
// Counts vsync falling edges and opens a dump window between programmable frames,
// optionally armed only after a ROM download finishes plus a holdoff.
module frame_dump_trigger
  import frame_dump_trigger_pkg::*;
#(
  parameter int unsigned CW          = CW_DEFAULT,
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned STOP_FRAME  = 0,
  parameter bit          WAIT_DWN    = 1'b1,
  parameter int unsigned HOLDOFF     = 20000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          led,
  output logic [CW-1:0] frame_cnt,
  output logic          dump_en,
  output logic          dump_start,
  output logic          dump_stop,
  output logic [1:0]    st
);
  // A stop frame equal to the start frame would close and open at once; treat it as never-close.
  localparam int unsigned   STOP_EFF  = (STOP_FRAME == START_FRAME) ? 0 : STOP_FRAME;
  localparam logic [CW-1:0] START_C   = CW'(START_FRAME);
  localparam logic [CW-1:0] STOP_C    = CW'(STOP_EFF);
  localparam logic [31:0]   HOLD_INIT = 32'(HOLDOFF - 1);
  localparam logic [1:0]    ST_RST    = WAIT_DWN ? WAITDL : ARMED;

  logic vs_s, vs_rise, vs_fall;
  logic led_s, led_rise, led_fall;

  frame_dump_trigger_sync_edge #(.RST_VAL(1'b1)) u_vs_sync (
    .clk(clk), .rst_n(rst_n), .d_i(vs),
    .lvl_o(vs_s), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  frame_dump_trigger_sync_edge #(.RST_VAL(1'b0)) u_led_sync (
    .clk(clk), .rst_n(rst_n), .d_i(led),
    .lvl_o(led_s), .rise_o(led_rise), .fall_o(led_fall)
  );

  logic unused_sync;
  assign unused_sync = vs_s ^ vs_rise ^ led_s;

  logic led_rise_g, led_fall_g;
  assign led_rise_g = WAIT_DWN && led_rise;
  assign led_fall_g = WAIT_DWN && led_fall;

  logic [CW-1:0] cnt_q, cnt_d, frame_inc;
  logic [1:0]    st_q, st_d;
  logic [31:0]   hold_q, hold_d;
  logic          done_q, done_d;
  logic          start_q, start_d, stop_q, stop_d;
  logic          start_ok, stop_hit;

  assign frame_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  if (START_FRAME == 0) begin : g_start_any
    assign start_ok = 1'b1;
  end else begin : g_start_cmp
    assign start_ok = (frame_inc >= START_C);
  end

  assign stop_hit = (STOP_EFF != 0) && (frame_inc == STOP_C);

  always_comb begin
    cnt_d   = vs_fall ? frame_inc : cnt_q;
    st_d    = st_q;
    hold_d  = hold_q;
    done_d  = done_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    case (st_q)
      WAITDL: begin
        if (led_fall_g) begin
          if (HOLDOFF == 0) begin
            st_d = ARMED;
          end else begin
            st_d   = HOLD;
            hold_d = HOLD_INIT;
          end
        end
      end
      HOLD: begin
        if (led_rise_g)        st_d = WAITDL;
        else if (hold_q == 0)  st_d = ARMED;
        else                   hold_d = hold_q - 32'd1;
      end
      ARMED: begin
        // A new download takes priority over a coincident frame edge.
        if (led_rise_g) begin
          st_d   = WAITDL;
          done_d = 1'b0;
        end else if (!done_q && vs_fall && start_ok) begin
          st_d    = DUMP;
          start_d = 1'b1;
        end
      end
      DUMP: begin
        if (led_rise_g) begin
          st_d   = WAITDL;
          done_d = 1'b0;
          stop_d = 1'b1;
        end else if (vs_fall && stop_hit) begin
          st_d   = ARMED;
          done_d = 1'b1;
          stop_d = 1'b1;
        end
      end
      default: st_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      st_q    <= ST_RST;
      hold_q  <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign frame_cnt  = cnt_q;
  assign dump_en    = (st_q == DUMP);
  assign dump_start = start_q;
  assign dump_stop  = stop_q;
  assign st         = st_q;
endmodule

// File: tb/tb_frame_dump_trigger.sv
// Three trigger configurations share vs/led; a frame-level model predicts window events and levels.
module tb_frame_dump_trigger;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b1;
  logic led = 1'b0;

  always #5 clk = ~clk;

  logic [31:0] fc[3];
  logic [31:0] fc0, fc1;
  logic [3:0]  fc2;
  logic [2:0]  en, ds, dp;
  logic [1:0]  st[3];

  frame_dump_trigger #(.CW(32), .START_FRAME(0), .STOP_FRAME(0), .WAIT_DWN(1'b0), .HOLDOFF(20000)) u0 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .led(led), .frame_cnt(fc0),
    .dump_en(en[0]), .dump_start(ds[0]), .dump_stop(dp[0]), .st(st[0]));
  frame_dump_trigger #(.CW(32), .START_FRAME(5), .STOP_FRAME(8), .WAIT_DWN(1'b1), .HOLDOFF(10)) u1 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .led(led), .frame_cnt(fc1),
    .dump_en(en[1]), .dump_start(ds[1]), .dump_stop(dp[1]), .st(st[1]));
  frame_dump_trigger #(.CW(4), .START_FRAME(3), .STOP_FRAME(3), .WAIT_DWN(1'b0), .HOLDOFF(7)) u2 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .led(led), .frame_cnt(fc2),
    .dump_en(en[2]), .dump_start(ds[2]), .dump_stop(dp[2]), .st(st[2]));

  assign fc[0] = fc0;
  assign fc[1] = fc1;
  assign fc[2] = {28'd0, fc2};

  // Model: 0 waiting for download, 1 holdoff, 2 armed, 3 dumping.
  int  P_START[3] = '{0, 5, 3};
  int  P_STOP[3]  = '{0, 8, 0};
  bit  P_WAIT[3]  = '{1'b0, 1'b1, 1'b0};
  int  P_MAX[3]   = '{32'h7fffffff, 32'h7fffffff, 15};
  int  m_cnt[3];
  int  m_mode[3];
  bit  m_done[3];

  typedef struct { bit stop; int cnt; } ev_t;
  ev_t exp_q[3][$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]  = 0;
      m_mode[k] = P_WAIT[k] ? 0 : 2;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic push_ev(input int k, input bit stop);
    ev_t e;
    e.stop = stop;
    e.cnt  = m_cnt[k];
    exp_q[k].push_back(e);
  endtask

  task automatic m_step(input bit vsf, input bit lr);
    for (int k = 0; k < 3; k++) begin
      if (vsf && m_cnt[k] < P_MAX[k]) m_cnt[k]++;
      if (lr && P_WAIT[k]) begin
        if (m_mode[k] == 3) push_ev(k, 1'b1);
        m_mode[k] = 0;
        m_done[k] = 1'b0;
      end else if (vsf) begin
        if (m_mode[k] == 2 && !m_done[k] && m_cnt[k] >= P_START[k]) begin
          push_ev(k, 1'b0);
          m_mode[k] = 3;
        end else if (m_mode[k] == 3 && P_STOP[k] != 0 && m_cnt[k] == P_STOP[k]) begin
          push_ev(k, 1'b1);
          m_mode[k] = 2;
          m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic quiet(input string tag);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.cnt%0d", tag, k), fc[k], m_cnt[k]);
      chk($sformatf("%s.en%0d", tag, k), en[k], (m_mode[k] == 3) ? 1 : 0);
      chk($sformatf("%s.st%0d", tag, k), st[k], m_mode[k]);
    end
  endtask

  task automatic pulse(input bit with_led);
    @(posedge clk); #1;
    vs = 1'b0;
    if (with_led) led = 1'b1;
    m_step(1'b1, with_led);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 vs = 1'b1;
    repeat ($urandom_range(6, 14)) @(posedge clk);
    quiet("pulse");
  endtask

  task automatic led_set(input bit v);
    int hc;
    @(posedge clk); #1;
    led = v;
    if (v) begin
      m_step(1'b0, 1'b1);
      repeat (10) @(posedge clk);
    end else begin
      hc = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (st[1] == 2'd1) hc++;
      end
      chk("hold_cycles", hc, 10);
      for (int k = 0; k < 3; k++)
        if (P_WAIT[k] && m_mode[k] == 0) m_mode[k] = 2;
    end
    quiet(v ? "led_hi" : "led_lo");
  endtask

  // Monitor: every start/stop pulse must match the next predicted event.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ds[k] || dp[k]) begin
          ev_t e;
          chk($sformatf("excl%0d", k), ds[k] & dp[k], 0);
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_pulse%0d", k), 1, 0);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("ev_kind%0d", k), dp[k], e.stop);
            chk($sformatf("ev_cnt%0d", k), fc[k], e.cnt);
          end
        end
      end
    end
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.cnt%0d", k), fc[k], 0);
      chk($sformatf("rst.en%0d", k), en[k], 0);
      chk($sformatf("rst.st%0d", k), st[k], m_mode[k]);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Download in progress: frames count, only the non-waiting configs open.
    led_set(1'b1);
    repeat ($urandom_range(2, 4)) pulse(1'b0);
    repeat (50) @(posedge clk);
    led_set(1'b0);

    // Run through the 5..8 window and on past the u2 saturation point.
    while (m_cnt[1] < 20) pulse(1'b0);

    // Re-download after done, reopen, then close via coincident download start and frame edge.
    led_set(1'b1);
    led_set(1'b0);
    pulse(1'b0);
    pulse(1'b1);
    led_set(1'b0);
    repeat ($urandom_range(1, 3)) pulse(1'b0);

    // Asynchronous reset in the middle of an open window.
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst.cnt%0d", k), fc[k], 0);
      chk($sformatf("arst.en%0d", k), en[k], 0);
      chk($sformatf("arst.stop%0d", k), dp[k], 0);
    end
    m_reset();
    repeat (2) @(posedge clk);
    quiet("arst");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    pulse(1'b0);

    repeat (10) @(posedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("pending%0d", k), exp_q[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
